// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types, widths and helpers for the spiking-neuron
//               datapath (synapse driver, neuron and future synapse blocks).
// Contents    : CURRENT_W, WEIGHT_W, CURRENT_MAX, current_t, weight_t,
//               sat_current() (clamps a signed accumulator into current_t).
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int         CURRENT_W   = 8;
    localparam int         WEIGHT_W    = 8;
    localparam logic [7:0] CURRENT_MAX = 8'd255;

    // Width of the accumulator argument of sat_current(); callers sign-extend.
    localparam int         SAT_ACC_W   = 32;

    typedef logic        [CURRENT_W-1:0] current_t;
    typedef logic signed [WEIGHT_W-1:0]  weight_t;

    // Clamp a signed accumulator into the unsigned current range [0, 255].
    function automatic current_t sat_current(input logic signed [SAT_ACC_W-1:0] acc);
        logic signed [SAT_ACC_W-1:0] max_s;
        max_s = signed'(SAT_ACC_W'(CURRENT_MAX));
        if (acc < 0) begin
            return '0;
        end else if (acc > max_s) begin
            return CURRENT_MAX;
        end else begin
            return acc[CURRENT_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/syn_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : syn_weight_bank
// Description : N_INPUTS x 8-bit signed weight register file with a single
//               write port, plus a combinational sum of the weights whose
//               spike line is high.
// Ports       : clk_i, rst_ni   clock, async active-low reset (weights -> 0)
//               i_we, i_waddr,  weight write port; addresses >= N_INPUTS
//               i_wdata         are ignored
//               i_spike         presynaptic spike mask
//               o_sum           signed sum of selected weights (ACC_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module syn_weight_bank
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int AW       = 2,
    parameter int ACC_W    = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic [WEIGHT_W-1:0]     i_wdata,
    input  logic [N_INPUTS-1:0]     i_spike,
    output logic signed [ACC_W-1:0] o_sum
);

    weight_t r_w [N_INPUTS];

    // Address decode by equality, so out-of-range addresses match no entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                r_w[k] <= '0;
            end
        end else if (i_we) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                if (i_waddr == AW'(k)) begin
                    r_w[k] <= weight_t'(i_wdata);
                end
            end
        end
    end

    // Reads the registered weights, so a same-cycle write is seen next edge.
    always_comb begin
        o_sum = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (i_spike[k]) begin
                o_sum = o_sum + ACC_W'(r_w[k]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/synapse_driver.sv
`default_nettype none
// ============================================================================
// Module      : synapse_driver
// Description : Synaptic input stage of a LIF neuron. Accumulates weighted
//               presynaptic spikes into a leaky, clamped synaptic current and
//               gates it to zero for a refractory window after a post-spike.
// Ports       : clk_i, rst_ni       clock, async active-low reset
//               spike_i             presynaptic spikes (N_INPUTS bits)
//               post_spike_i        downstream neuron spike feedback
//               we_i/waddr_i/wdata_i weight write port
//               current_o           unsigned synaptic current (registered)
//               refrac_o            refractory counter nonzero
//               sat_o               previous update clamped at the top
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_driver
    import snn_pkg::*;
#(
    parameter  int N_INPUTS      = 4,
    parameter  int DECAY_SHIFT   = 2,
    parameter  int REFRAC_CYCLES = 3,
    localparam int AW            = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_INPUTS-1:0] spike_i,
    input  logic                post_spike_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [WEIGHT_W-1:0] wdata_i,
    output logic [CURRENT_W-1:0] current_o,
    output logic                refrac_o,
    output logic                sat_o
);

    // Wide enough for 255 plus N_INPUTS full-scale weights of either sign.
    localparam int ACC_W = CURRENT_W + $clog2(N_INPUTS) + 2;
    localparam logic signed [ACC_W-1:0] C_ACC_MAX = signed'(ACC_W'(CURRENT_MAX));

    current_t                r_syn;
    logic [3:0]              r_cnt;
    logic                    r_sat;

    logic signed [ACC_W-1:0] w_sum;
    current_t                w_decay;
    logic signed [ACC_W-1:0] w_acc;

    syn_weight_bank #(
        .N_INPUTS (N_INPUTS),
        .AW       (AW),
        .ACC_W    (ACC_W)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_we     (we_i),
        .i_waddr  (waddr_i),
        .i_wdata  (wdata_i),
        .i_spike  (spike_i),
        .o_sum    (w_sum)
    );

    // Below 2^DECAY_SHIFT the leak term is zero and the current holds.
    assign w_decay = r_syn >> DECAY_SHIFT;
    assign w_acc   = signed'(ACC_W'(r_syn)) - signed'(ACC_W'(w_decay)) + w_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_syn <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (post_spike_i) begin
            // Post-spike (re)starts the window regardless of current count.
            r_syn <= '0;
            r_cnt <= 4'(REFRAC_CYCLES);
            r_sat <= 1'b0;
        end else if (r_cnt != 4'd0) begin
            r_syn <= '0;
            r_cnt <= r_cnt - 4'd1;
            r_sat <= 1'b0;
        end else begin
            r_syn <= sat_current(SAT_ACC_W'(w_acc));
            r_sat <= (w_acc > C_ACC_MAX);
        end
    end

    assign current_o = r_syn;
    assign refrac_o  = (r_cnt != 4'd0);
    assign sat_o     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_synapse_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_synapse_driver
// Description : Directed self-checking bench for synapse_driver. Main
//               instance uses defaults (N=4, shift 2, refractory 3); a second
//               instance (N=3, refractory 0) covers out-of-range write
//               addresses and disabled refractory gating.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse_driver;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] spike_i;
    logic       post_spike_i;
    logic       we_i;
    logic [1:0] waddr_i;
    logic [7:0] wdata_i;
    logic [7:0] current_o;
    logic       refrac_o;
    logic       sat_o;

    logic [2:0] spike3;
    logic       post3;
    logic       we3;
    logic [1:0] waddr3;
    logic [7:0] wdata3;
    logic [7:0] current3;
    logic       refrac3;
    logic       sat3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    synapse_driver #(.N_INPUTS(4), .DECAY_SHIFT(2), .REFRAC_CYCLES(3)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .spike_i      (spike_i),
        .post_spike_i (post_spike_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .current_o    (current_o),
        .refrac_o     (refrac_o),
        .sat_o        (sat_o)
    );

    synapse_driver #(.N_INPUTS(3), .DECAY_SHIFT(2), .REFRAC_CYCLES(0)) u_dut3 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .spike_i      (spike3),
        .post_spike_i (post3),
        .we_i         (we3),
        .waddr_i      (waddr3),
        .wdata_i      (wdata3),
        .current_o    (current3),
        .refrac_o     (refrac3),
        .sat_o        (sat3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle just past it before sampling/driving.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int cur, input int rf, input int st);
        chk({tag, ".cur"}, int'(current_o), cur);
        chk({tag, ".ref"}, int'(refrac_o), rf);
        chk({tag, ".sat"}, int'(sat_o), st);
    endtask

    // Pulse reset low between edges and check outputs clear without an edge.
    task automatic mid_reset(input string tag);
        #2 rst_ni = 1'b0;
        #1 chk_out(tag, 0, 0, 0);
        #2 rst_ni = 1'b1;
    endtask

    initial begin
        int dec_exp [4] = '{30, 23, 18, 14};
        int rf1_exp [6] = '{1, 1, 1, 0, 0, 0};
        int rf2_exp [7] = '{1, 1, 1, 1, 1, 0, 0};

        rst_ni = 1'b0; spike_i = '0; post_spike_i = 1'b0;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        spike3 = '0; post3 = 1'b0; we3 = 1'b0; waddr3 = '0; wdata3 = '0;
        #2 chk_out("reset", 0, 0, 0);
        tick(); tick();
        chk_out("reset_hold", 0, 0, 0);
        rst_ni = 1'b1;

        // Decay: 40 -> 30 -> 23 -> 18 -> 14
        wr(2'd0, 8'd40);
        wr(2'd1, 8'hCE);               // -50
        spike_i = 4'b0001; tick(); spike_i = '0;
        chk_out("decay0", 40, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("decay%0d", i + 1), int'(current_o), dec_exp[i]);
        end

        // Clear with a post-spike, wait out the window.
        post_spike_i = 1'b1; tick(); post_spike_i = 1'b0;
        chk_out("clr_post", 0, 1, 0);
        tick(); tick(); tick();
        chk_out("clr_done", 0, 0, 0);

        // Inhibition: 30 - 7 - 50 = -27 -> 0
        spike_i = 4'b0001; tick(); spike_i = '0;
        tick();
        chk("inh_pre", int'(current_o), 30);
        spike_i = 4'b0010; tick(); spike_i = '0;
        chk_out("inhibit", 0, 0, 0);

        // Saturation: 4 x 127 every cycle
        for (int k = 0; k < 4; k++) wr(2'(k), 8'd127);
        spike_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("sat%0d", i), 255, 0, 1);
        end
        spike_i = '0; tick();
        chk_out("sat_drop", 192, 0, 0);

        // Async reset while saturated; weights must read back zero.
        spike_i = 4'hF; tick();
        chk_out("sat_again", 255, 0, 1);
        mid_reset("rst_sat");
        tick();
        chk_out("rst_wzero", 0, 0, 0);
        spike_i = '0;

        // Refractory: weights 10, spikes held, 40/70/93 ramp, then post-spike.
        for (int k = 0; k < 4; k++) wr(2'(k), 8'd10);
        spike_i = 4'hF;
        tick(); tick(); tick();
        chk("ramp", int'(current_o), 93);
        post_spike_i = 1'b1; tick(); post_spike_i = 1'b0;
        chk_out("ref_t0", 0, rf1_exp[0], 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_out($sformatf("ref_t%0d", i), 0, rf1_exp[i], 0);
        end
        tick();
        chk_out("ref_t4", 40, 0, 0);

        // Second post-spike two edges in extends the window by two.
        post_spike_i = 1'b1; tick(); post_spike_i = 1'b0;
        chk_out("ext_t0", 0, rf2_exp[0], 0);
        tick();
        chk_out("ext_t1", 0, rf2_exp[1], 0);
        post_spike_i = 1'b1; tick(); post_spike_i = 1'b0;
        chk_out("ext_t2", 0, rf2_exp[2], 0);
        for (int i = 3; i < 6; i++) begin
            tick();
            chk_out($sformatf("ext_t%0d", i), 0, rf2_exp[i], 0);
        end
        tick();
        chk_out("ext_t6", 40, 0, 0);

        // Async reset with refractory count at 2.
        post_spike_i = 1'b1; tick(); post_spike_i = 1'b0;
        tick();
        chk("rst_cnt_pre", int'(refrac_o), 1);
        mid_reset("rst_ref");
        spike_i = '0;

        // Write collision: accumulate with old w2, then new w2.
        wr(2'd2, 8'd20);
        spike_i = 4'b0100; we_i = 1'b1; waddr_i = 2'd2; wdata_i = 8'd90;
        tick();
        we_i = 1'b0;
        chk_out("coll_old", 20, 0, 0);
        tick();
        chk_out("coll_new", 105, 0, 0);
        spike_i = '0;

        // N=3 instance: address 3 is out of range, address 2 is live.
        we3 = 1'b1; waddr3 = 2'd3; wdata3 = 8'd60; tick(); we3 = 1'b0;
        spike3 = 3'b111; tick(); spike3 = '0;
        chk("oor_ignored", int'(current3), 0);
        we3 = 1'b1; waddr3 = 2'd2; wdata3 = 8'd60; tick(); we3 = 1'b0;
        spike3 = 3'b111; tick();
        chk("n3_live", int'(current3), 60);

        // REFRAC_CYCLES=0: post-spike zeroes one edge, no refractory flag.
        post3 = 1'b1; tick(); post3 = 1'b0;
        chk("r0_zero", int'(current3), 0);
        chk("r0_ref", int'(refrac3), 0);
        tick();
        chk("r0_resume", int'(current3), 60);
        chk("r0_sat", int'(sat3), 0);
        spike3 = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
